// File: rtl/tx_128b130b_lane_framer.sv
// tx_128b130b_lane_framer: 128b/130b transmit framer with a per-lane sync header,
//   per-lane 23-bit LFSR scrambling and one-bit-per-clock serialisation.
// Latency: a block accepted at edge E shows H0 after edge E+1 and its last payload bit after edge E+130.
// Backpressure: one holding register, tx_ready = ~hold_full; output is gapless when the next block
//   is accepted no later than the edge that presents index 129.
//
// Ports:
//   clk1        block clock, all logic on the rising edge
//   rst1        asynchronous active-low reset
//   tx_valid    block present on DLL_data / k / en_scram
//   tx_ready    holding register empty, a block can be accepted
//   DLL_data    LANES x 128-bit payload, lane L in bits [L*128 +: 128]
//   k           1 = ordered-set block, 0 = data block
//   en_scram    1 = scramble the payload of a data block
//   lfsr_reseed pulse, all lanes reseed at the next block load
//   data_out    registered serial bit per lane
//   block_start high while data_out carries H0
//   tx_active   high while a block is being shifted out
module tx_128b130b_lane_framer #(
  parameter int LANES = 4
) (
  input  logic                 clk1,
  input  logic                 rst1,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [LANES*128-1:0] DLL_data,
  input  logic                 k,
  input  logic                 en_scram,
  input  logic                 lfsr_reseed,
  output logic [LANES-1:0]     data_out,
  output logic                 block_start,
  output logic                 tx_active
);

  localparam logic [7:0]  LAST_IDX = 8'd129;
  localparam logic [22:0] LFSR_TAPS = 23'h210125;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Seed table repeats every eight lanes.
  function automatic logic [22:0] lane_seed(input int lane);
    logic [22:0] s;
    case (lane % 8)
      0:       s = 23'h1DBFBC;
      1:       s = 23'h0607BB;
      2:       s = 23'h1EC760;
      3:       s = 23'h18C0DB;
      4:       s = 23'h010F12;
      5:       s = 23'h19CFC9;
      6:       s = 23'h0277CE;
      default: s = 23'h1BB807;
    endcase
    return s;
  endfunction

  // Galois step for x^23+x^21+x^16+x^8+x^5+x^2+1; the bit shifted out is lfsr[22].
  function automatic logic [22:0] lfsr_step(input logic [22:0] cur);
    return {cur[21:0], 1'b0} ^ (cur[22] ? LFSR_TAPS : 23'h0);
  endfunction

  // Holding stage
  logic                    hold_full_q, hold_full_d;
  logic [LANES-1:0][127:0] hold_dat_q, hold_dat_d;
  logic                    hold_k_q, hold_k_d;
  logic                    hold_scr_q, hold_scr_d;

  // Shift stage
  state_t                  state_q, state_d;
  logic [7:0]              idx_q, idx_d;
  logic [LANES-1:0][127:0] sh_dat_q, sh_dat_d;
  logic                    sh_k_q, sh_k_d;
  logic                    sh_scr_q, sh_scr_d;

  // Scrambler and reseed request
  logic [LANES-1:0][22:0]  lfsr_q, lfsr_d;
  logic                    reseed_q, reseed_d;

  // Registered outputs
  logic [LANES-1:0]        data_out_q, data_out_d;
  logic                    block_start_q, block_start_d;
  logic                    tx_active_q, tx_active_d;

  logic                    accept;
  logic                    load;

  always_comb begin
    accept = tx_valid & ~hold_full_q;
    // A load happens from IDLE, or on the edge that retires index 129 of the current block.
    load   = hold_full_q & ((state_q == ST_IDLE) || ((state_q == ST_SEND) && (idx_q == LAST_IDX)));

    hold_full_d   = hold_full_q;
    hold_dat_d    = hold_dat_q;
    hold_k_d      = hold_k_q;
    hold_scr_d    = hold_scr_q;
    state_d       = state_q;
    idx_d         = idx_q;
    sh_dat_d      = sh_dat_q;
    sh_k_d        = sh_k_q;
    sh_scr_d      = sh_scr_q;
    lfsr_d        = lfsr_q;
    reseed_d      = reseed_q | lfsr_reseed;
    data_out_d    = '0;
    block_start_d = 1'b0;
    tx_active_d   = 1'b0;

    // Holding register: a same-edge accept keeps it full even while it is being drained.
    if (load) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_dat_d  = DLL_data;
      hold_k_d    = k;
      hold_scr_d  = en_scram;
    end

    if (load) begin
      state_d  = ST_SEND;
      idx_d    = 8'd0;
      sh_dat_d = hold_dat_q;
      sh_k_d   = hold_k_q;
      // Ordered-set blocks are never scrambled, so fold k into the enable here.
      sh_scr_d = hold_scr_q & ~hold_k_q;
      // A reseed pulse on this very edge applies to this load.
      if (reseed_q | lfsr_reseed) begin
        for (int l = 0; l < LANES; l++) begin
          lfsr_d[l] = lane_seed(l);
        end
      end
      reseed_d      = 1'b0;
      data_out_d    = {LANES{hold_k_q}};  // H0: 1 for ordered set, 0 for data
      block_start_d = 1'b1;
      tx_active_d   = 1'b1;
    end else if (state_q == ST_SEND) begin
      if (idx_q == LAST_IDX) begin
        // Underrun: nothing waiting, drop to IDLE with quiet outputs.
        state_d = ST_IDLE;
        idx_d   = 8'd0;
      end else begin
        idx_d       = idx_q + 8'd1;
        tx_active_d = 1'b1;
        if (idx_q == 8'd0) begin
          data_out_d = {LANES{~sh_k_q}};  // H1 is the complement of H0
        end else begin
          // Payload leaves LSB first from the bottom of each lane's shift register.
          for (int l = 0; l < LANES; l++) begin
            data_out_d[l] = sh_dat_q[l][0] ^ (sh_scr_q & lfsr_q[l][22]);
            sh_dat_d[l]   = {1'b0, sh_dat_q[l][127:1]};
            if (sh_scr_q) begin
              lfsr_d[l] = lfsr_step(lfsr_q[l]);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst1) begin
    if (!rst1) begin
      hold_full_q   <= 1'b0;
      hold_dat_q    <= '0;
      hold_k_q      <= 1'b0;
      hold_scr_q    <= 1'b0;
      state_q       <= ST_IDLE;
      idx_q         <= 8'd0;
      sh_dat_q      <= '0;
      sh_k_q        <= 1'b0;
      sh_scr_q      <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        lfsr_q[l] <= lane_seed(l);
      end
      reseed_q      <= 1'b0;
      data_out_q    <= '0;
      block_start_q <= 1'b0;
      tx_active_q   <= 1'b0;
    end else begin
      hold_full_q   <= hold_full_d;
      hold_dat_q    <= hold_dat_d;
      hold_k_q      <= hold_k_d;
      hold_scr_q    <= hold_scr_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      sh_dat_q      <= sh_dat_d;
      sh_k_q        <= sh_k_d;
      sh_scr_q      <= sh_scr_d;
      lfsr_q        <= lfsr_d;
      reseed_q      <= reseed_d;
      data_out_q    <= data_out_d;
      block_start_q <= block_start_d;
      tx_active_q   <= tx_active_d;
    end
  end

  assign tx_ready    = ~hold_full_q;
  assign data_out    = data_out_q;
  assign block_start = block_start_q;
  assign tx_active   = tx_active_q;

endmodule

// File: tb/tb_tx_128b130b_lane_framer.sv
module tb_tx_128b130b_lane_framer;
  localparam int LANES = 16;
  localparam int W     = LANES * 128;
  localparam int MAXC  = 4096;

  logic             clk1;
  logic             rst1;
  logic             tx_valid;
  logic             tx_ready;
  logic [W-1:0]     DLL_data;
  logic             k;
  logic             en_scram;
  logic             lfsr_reseed;
  logic [LANES-1:0] data_out;
  logic             block_start;
  logic             tx_active;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Per-cycle record of outputs, indexed by number of rising edges seen.
  logic [LANES-1:0] rec_d   [MAXC];
  logic             rec_bs  [MAXC];
  logic             rec_act [MAXC];
  logic             rec_rdy [MAXC];

  // Reference model state
  logic [22:0]  m_lfsr [LANES];
  bit           m_reseed;
  logic [129:0] m_exp  [LANES];

  tx_128b130b_lane_framer #(.LANES(LANES)) dut (
    .clk1        (clk1),
    .rst1        (rst1),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .DLL_data    (DLL_data),
    .k           (k),
    .en_scram    (en_scram),
    .lfsr_reseed (lfsr_reseed),
    .data_out    (data_out),
    .block_start (block_start),
    .tx_active   (tx_active)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  always @(posedge clk1) cyc <= cyc + 1;

  always @(negedge clk1) begin
    if (cyc < MAXC) begin
      rec_d[cyc]   <= data_out;
      rec_bs[cyc]  <= block_start;
      rec_act[cyc] <= tx_active;
      rec_rdy[cyc] <= tx_ready;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [22:0] seed_of(input int l);
    logic [22:0] t [8];
    t[0] = 23'h1DBFBC; t[1] = 23'h0607BB; t[2] = 23'h1EC760; t[3] = 23'h18C0DB;
    t[4] = 23'h010F12; t[5] = 23'h19CFC9; t[6] = 23'h0277CE; t[7] = 23'h1BB807;
    return t[l % 8];
  endfunction

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) m_lfsr[l] = seed_of(l);
    m_reseed = 0;
  endtask

  // Expected 130-bit stream per lane, bit i = the bit sent at index i.
  task automatic model_block(input logic [W-1:0] dat, input logic kk, input logic sc);
    logic [22:0] s;
    logic        ks;
    logic        b;
    if (m_reseed) begin
      for (int l = 0; l < LANES; l++) m_lfsr[l] = seed_of(l);
      m_reseed = 0;
    end
    for (int l = 0; l < LANES; l++) begin
      m_exp[l][0] = kk;
      m_exp[l][1] = ~kk;
      s = m_lfsr[l];
      for (int j = 0; j < 128; j++) begin
        b = dat[l*128 + j];
        if (!kk && sc) begin
          ks = s[22];
          b  = b ^ ks;
          s  = s << 1;
          if (ks) s = s ^ 23'h210125;
        end
        m_exp[l][j+2] = b;
      end
      m_lfsr[l] = s;
    end
  endtask

  // ---------------- record accessors ----------------
  function automatic logic [129:0] lane_bits(input int s, input int l);
    logic [129:0] v;
    for (int i = 0; i < 130; i++) v[i] = (s+i >= 0 && s+i < MAXC) ? rec_d[s+i][l] : 1'bx;
    return v;
  endfunction

  function automatic logic [129:0] bs_bits(input int s);
    logic [129:0] v;
    for (int i = 0; i < 130; i++) v[i] = (s+i >= 0 && s+i < MAXC) ? rec_bs[s+i] : 1'bx;
    return v;
  endfunction

  function automatic logic [129:0] act_bits(input int s);
    logic [129:0] v;
    for (int i = 0; i < 130; i++) v[i] = (s+i >= 0 && s+i < MAXC) ? rec_act[s+i] : 1'bx;
    return v;
  endfunction

  function automatic bit idle_ok(input int from, input int n);
    bit ok = 1;
    for (int c = from; c < from + n; c++) begin
      if (c < 0 || c >= MAXC) ok = 0;
      else if (rec_d[c] !== '0 || rec_bs[c] !== 1'b0 || rec_act[c] !== 1'b0) ok = 0;
    end
    return ok;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic rand_payload(output logic [W-1:0] d);
    for (int w = 0; w < W/32; w++) d[w*32 +: 32] = $urandom;
  endtask

  task automatic wait_until(input int target);
    for (int n = 0; n < 2000 && cyc < target; n++) @(negedge clk1);
    if (cyc < target) begin
      checks++; errors++;
      $display("FAIL wait_until cycle %0d never reached (at %0d)", target, cyc);
    end
    #1;
  endtask

  // Presents a block and returns the record index just after its accept edge.
  task automatic send_block(input logic [W-1:0] dat, input logic kk, input logic sc, output int acc);
    bit done = 0;
    DLL_data = dat; k = kk; en_scram = sc; tx_valid = 1'b1;
    for (int n = 0; n < 600 && !done; n++) begin
      if (tx_ready === 1'b1) begin
        @(posedge clk1);
        done = 1;
      end else begin
        @(negedge clk1);
      end
    end
    @(negedge clk1);
    acc = cyc;
    tx_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_block not accepted got tx_ready=%b want 1", tx_ready);
    end
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst1 = 1'b0; tx_valid = 1'b0; lfsr_reseed = 1'b0;
    repeat (3) @(negedge clk1);
    rst1 = 1'b1;
    model_reset();
    @(negedge clk1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int st;
    @(negedge clk1);
    #2;
    checks++;
    if (data_out !== '0) begin errors++; $display("FAIL reset_data_out got %h want 0", data_out); end
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
    checks++;
    if (block_start !== 1'b0 || tx_active !== 1'b0) begin
      errors++; $display("FAIL reset_flags got bs=%b act=%b want 0 0", block_start, tx_active);
    end
    repeat (2) @(negedge clk1);
    rst1 = 1'b1;
    model_reset();
    st = cyc;
    wait_until(st + 12);
    checks++;
    if (idle_ok(st, 10) !== 1'b1) begin errors++; $display("FAIL reset_idle got activity want quiet outputs"); end
    checks++;
    if (rec_rdy[st+5] !== 1'b1) begin errors++; $display("FAIL reset_idle_ready got %b want 1", rec_rdy[st+5]); end
  endtask

  task automatic test_single_data();
    logic [W-1:0] d;
    logic [129:0] want0 = 130'h6;
    logic [129:0] bs_want = 130'd1;
    logic [129:0] act_want = '1;
    int a, s, bad;
    do_reset();
    rand_payload(d);
    d[127:0] = 128'h1;
    send_block(d, 1'b0, 1'b0, a);
    s = a + 1;
    wait_until(s + 136);
    model_block(d, 1'b0, 1'b0);
    checks++;
    if (lane_bits(s, 0) !== want0) begin errors++; $display("FAIL single_lane0 got %h want %h", lane_bits(s, 0), want0); end
    bad = -1;
    for (int l = 0; l < LANES; l++) if (bad < 0 && lane_bits(s, l) !== m_exp[l]) bad = l;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL single_lanes lane %0d got %h want %h", bad, lane_bits(s, bad), m_exp[bad]); end
    checks++;
    if (bs_bits(s) !== bs_want) begin errors++; $display("FAIL single_block_start got %h want %h", bs_bits(s), bs_want); end
    checks++;
    if (act_bits(s) !== act_want) begin errors++; $display("FAIL single_tx_active got %h want %h", act_bits(s), act_want); end
    checks++;
    if (idle_ok(a, 1) !== 1'b1 || idle_ok(s + 130, 5) !== 1'b1) begin
      errors++; $display("FAIL single_latency_idle got activity outside 130 cycles want quiet");
    end
    checks++;
    if ({rec_rdy[a-1], rec_rdy[a], rec_rdy[s]} !== 3'b101) begin
      errors++; $display("FAIL single_tx_ready got %b%b%b want 101", rec_rdy[a-1], rec_rdy[a], rec_rdy[s]);
    end
  endtask

  task automatic test_ordered_set();
    logic [W-1:0] ones = '1;
    logic [W-1:0] zeros = '0;
    logic [129:0] os_want = {{128{1'b1}}, 2'b01};
    logic [129:0] bs_want = 130'd1;
    int a, a2, s, s2, bad;
    do_reset();
    send_block(ones, 1'b1, 1'b1, a);
    send_block(zeros, 1'b0, 1'b1, a2);
    s  = a + 1;
    s2 = s + 130;
    wait_until(s2 + 136);
    model_block(ones, 1'b1, 1'b1);
    bad = -1;
    for (int l = 0; l < LANES; l++) if (bad < 0 && lane_bits(s, l) !== os_want) bad = l;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL os_lanes lane %0d got %h want %h", bad, lane_bits(s, bad), os_want); end
    model_block(zeros, 1'b0, 1'b1);
    bad = -1;
    for (int l = 0; l < LANES; l++) if (bad < 0 && lane_bits(s2, l) !== m_exp[l]) bad = l;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL os_lfsr_held lane %0d got %h want %h", bad, lane_bits(s2, bad), m_exp[bad]); end
    checks++;
    if (bs_bits(s2) !== bs_want || bs_bits(s) !== bs_want) begin
      errors++; $display("FAIL os_block_start got %h/%h want %h", bs_bits(s), bs_bits(s2), bs_want);
    end
  endtask

  task automatic test_scrambled_zero();
    logic [W-1:0] zeros = '0;
    int a, s, bad;
    do_reset();
    send_block(zeros, 1'b0, 1'b1, a);
    s = a + 1;
    wait_until(s + 136);
    model_block(zeros, 1'b0, 1'b1);
    bad = -1;
    for (int l = 0; l < LANES; l++) if (bad < 0 && lane_bits(s, l) !== m_exp[l]) bad = l;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL scr_zero lane %0d got %h want %h", bad, lane_bits(s, bad), m_exp[bad]); end
    checks++;
    if (lane_bits(s, 8) !== m_exp[0]) begin errors++; $display("FAIL scr_lane8_seed got %h want %h", lane_bits(s, 8), m_exp[0]); end
    checks++;
    if (idle_ok(s + 130, 5) !== 1'b1) begin errors++; $display("FAIL scr_zero_tail got activity want quiet"); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] bd [3];
    logic         bk [3];
    logic         bsc [3];
    logic [129:0] bs_want = 130'd1;
    logic [129:0] act_want = '1;
    int a [3];
    int s, sb, bad;
    do_reset();
    for (int b = 0; b < 3; b++) begin
      rand_payload(bd[b]);
      bk[b]  = (b == 1) ? ($urandom_range(0, 1) != 0) : 1'b0;
      bsc[b] = (b == 1) ? ($urandom_range(0, 1) != 0) : 1'b1;
    end
    for (int b = 0; b < 3; b++) send_block(bd[b], bk[b], bsc[b], a[b]);
    s = a[0] + 1;
    wait_until(s + 400);
    for (int b = 0; b < 3; b++) begin
      sb = s + 130*b;
      model_block(bd[b], bk[b], bsc[b]);
      bad = -1;
      for (int l = 0; l < LANES; l++) if (bad < 0 && lane_bits(sb, l) !== m_exp[l]) bad = l;
      checks++;
      if (bad >= 0) begin errors++; $display("FAIL b2b_data blk %0d lane %0d got %h want %h", b, bad, lane_bits(sb, bad), m_exp[bad]); end
      checks++;
      if (bs_bits(sb) !== bs_want || act_bits(sb) !== act_want) begin
        errors++; $display("FAIL b2b_framing blk %0d got bs=%h act=%h want bs=%h act=%h", b, bs_bits(sb), act_bits(sb), bs_want, act_want);
      end
    end
    checks++;
    if (idle_ok(s + 390, 6) !== 1'b1) begin errors++; $display("FAIL b2b_tail got activity after 390 bits want quiet"); end
  endtask

  task automatic test_reseed_reset();
    logic [W-1:0] d1, d2;
    logic [129:0] mask60 = (130'd1 << 60) - 130'd1;
    int a1, a2, a3, a4, a5, s1, s3, s5, r, bad;
    do_reset();
    rand_payload(d1);
    rand_payload(d2);
    send_block(d1, 1'b0, 1'b1, a1);
    send_block(d2, 1'b0, 1'b1, a2);
    s1 = a1 + 1;
    wait_until(s1 + 266);
    model_block(d1, 1'b0, 1'b1);
    bad = -1;
    for (int l = 0; l < LANES; l++) if (bad < 0 && lane_bits(s1, l) !== m_exp[l]) bad = l;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL rs_blk1 lane %0d got %h want %h", bad, lane_bits(s1, bad), m_exp[bad]); end
    model_block(d2, 1'b0, 1'b1);
    bad = -1;
    for (int l = 0; l < LANES; l++) if (bad < 0 && lane_bits(s1 + 130, l) !== m_exp[l]) bad = l;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL rs_blk2 lane %0d got %h want %h", bad, lane_bits(s1 + 130, bad), m_exp[bad]); end

    lfsr_reseed = 1'b1;
    @(negedge clk1);
    lfsr_reseed = 1'b0;
    m_reseed = 1;
    send_block(d1, 1'b0, 1'b1, a3);
    s3 = a3 + 1;
    send_block(d2, 1'b0, 1'b1, a4);
    wait_until(s3 + 60);
    checks++;
    if (tx_active !== 1'b1 || tx_ready !== 1'b0) begin
      errors++; $display("FAIL rs_pre_reset got act=%b rdy=%b want act=1 rdy=0", tx_active, tx_ready);
    end
    rst1 = 1'b0;
    #1;
    checks++;
    if (data_out !== '0 || tx_ready !== 1'b1 || tx_active !== 1'b0 || block_start !== 1'b0) begin
      errors++; $display("FAIL rs_async_reset got d=%h rdy=%b act=%b bs=%b want 0 1 0 0", data_out, tx_ready, tx_active, block_start);
    end
    model_block(d1, 1'b0, 1'b1);
    bad = -1;
    for (int l = 0; l < LANES; l++) if (bad < 0 && (lane_bits(s3, l) & mask60) !== (m_exp[l] & mask60)) bad = l;
    checks++;
    if (bad >= 0) begin
      errors++; $display("FAIL rs_reseed_blk3 lane %0d got %h want %h", bad, lane_bits(s3, bad) & mask60, m_exp[bad] & mask60);
    end
    repeat (2) @(negedge clk1);
    rst1 = 1'b1;
    model_reset();
    r = cyc;
    wait_until(r + 7);
    checks++;
    if (idle_ok(r, 6) !== 1'b1) begin errors++; $display("FAIL rs_hold_cleared got activity after reset want quiet"); end
    send_block(d1, 1'b0, 1'b1, a5);
    s5 = a5 + 1;
    wait_until(s5 + 136);
    model_block(d1, 1'b0, 1'b1);
    bad = -1;
    for (int l = 0; l < LANES; l++) if (bad < 0 && lane_bits(s5, l) !== m_exp[l]) bad = l;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL rs_post_reset lane %0d got %h want %h", bad, lane_bits(s5, bad), m_exp[bad]); end
    checks++;
    if (idle_ok(s5 + 130, 5) !== 1'b1) begin errors++; $display("FAIL rs_tail got activity want quiet"); end
  endtask

  initial begin
    rst1 = 1'b0; tx_valid = 1'b0; k = 1'b0; en_scram = 1'b0; lfsr_reseed = 1'b0; DLL_data = '0;
    model_reset();
    test_reset();
    test_single_data();
    test_ordered_set();
    test_scrambled_zero();
    test_back_to_back();
    test_reseed_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
